// File: rtl/lab6_par2ser.sv
// lab6_par2ser: parallel-in, serial-out serializer, LSB first.
// A word is accepted through a valid/ready handshake and then sent one bit
// per shift_en strobe. A lab6 shift register clocked by the same strobe
// holds the original word once the frame is complete.
// Optional feature: define LAB6_PAR2SER_BACK2BACK_EN to accept the next
// word on the strobe that consumes the last bit, so frames run with no gap.
module lab6_par2ser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             out_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic last_bit;
  logic accept;

  assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept     = load_valid && load_ready;
  assign out_valid  = (state_q == SHIFT);
  // The zero fill in SHIFT keeps the line low once a frame has drained.
  assign serial_out = shreg_q[0];
  assign done       = done_q;

  // Ready decode: always ready when idle, optionally on the last strobe too.
  always_comb begin
    load_ready = (state_q == IDLE);
`ifdef LAB6_PAR2SER_BACK2BACK_EN
    if ((state_q == SHIFT) && shift_en && last_bit) begin
      load_ready = 1'b1;
    end
`else
`endif
  end

  // Next-state and datapath decode for the IDLE/SHIFT controller.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (last_bit) begin
            done_d = 1'b1;
            cnt_d  = '0;
            // accept can only be true here when back-to-back loading is on.
            if (accept) begin
              shreg_d = data_in;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, shift register, counter and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_lab6_par2ser.sv
// tb_lab6_par2ser: scoreboard bench for lab6_par2ser (WIDTH = 8).
// Stimulus pushes the expected bits and words when a load is accepted; an
// independent monitor compares line bits, done timing and a loopback lab6
// receiver against those queues.
module tb_lab6_par2ser;

  localparam int WIDTH = 8;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             serial_out;
  logic             out_valid;
  logic             done;

  exp_bit_t         sbq[$];
  logic [WIDTH-1:0] wq[$];
  int               done_cycles[$];

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: shift_en every cycle, 1: every third cycle, 2: off
  int cyc    = 0;
  int ov_low = 0;

  lab6_par2ser #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .serial_out (serial_out),
    .out_valid  (out_valid),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Strobe generator, driven just after each rising edge.
  initial begin
    int sc;
    sc = 0;
    shift_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sc++;
      case (mode)
        0:       shift_en = 1'b1;
        1:       shift_en = (sc % 3 == 0);
        default: shift_en = 1'b0;
      endcase
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on falling edges.
  initial begin
    logic             pending;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] w;
    exp_bit_t         e;
    pending = 1'b0;
    rx      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        pending = 1'b0;
        rx      = '0;
      end else begin
        check("done_timing", done, pending);
        if (done && pending) begin
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL loopback_word: done with no word expected at %0t", $time);
          end else begin
            w = wq.pop_front();
            check("loopback_word", rx, w);
          end
`ifdef LAB6_PAR2SER_BACK2BACK_EN
          done_cycles.push_back(cyc);
`else
          check("done_out_valid_low", out_valid, 1'b0);
`endif
        end
        pending = 1'b0;
`ifndef LAB6_PAR2SER_BACK2BACK_EN
        check("load_ready_decode", load_ready, !out_valid);
`endif
        if (!out_valid) ov_low++;
        if (out_valid) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bit: got out_valid 1 required 0 at %0t", $time);
          end else begin
            e = sbq[0];
            if (shift_en) begin
              check("bit_consumed", serial_out, e.b);
              void'(sbq.pop_front());
              rx      = {serial_out, rx[WIDTH-1:1]};
              pending = e.last;
            end else begin
              check("bit_held", serial_out, e.b);
            end
          end
        end else begin
          check("idle_line_zero", serial_out, 1'b0);
        end
      end
    end
  end

  // Present a word and wait (bounded) for the handshake to complete.
  task automatic send(input logic [WIDTH-1:0] word);
    logic acc;
    int   n;
    acc        = 1'b0;
    n          = 0;
    data_in    = word;
    load_valid = 1'b1;
    while (!acc && n < 300) begin
      @(negedge clk);
      if (load_ready) begin
        acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
          sbq.push_back('{b: word[i], last: (i == WIDTH - 1)});
        end
        wq.push_back(word);
      end
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: got no load_ready required handshake for %0h", word);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected bit and word has been seen.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sbq.size() != 0 || wq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0 || wq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d bits %0d words left required 0", name, sbq.size(), wq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    load_valid = 1'b0;
    #3;
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_serial_out", serial_out, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // A5 with continuous strobes: line 1,0,1,0,0,1,0,1.
    mode = 0;
    send(8'hA5);
    drain("a5");

    // 3C with a strobe only every third cycle.
    mode = 1;
    send(8'h3C);
    drain("3c");

`ifndef LAB6_PAR2SER_BACK2BACK_EN
    // FF offered during the 01 frame must wait for IDLE.
    mode = 0;
    send(8'h01);
    send(8'hFF);
    drain("01_ff");
`endif

    // F0 interrupted by reset after three strobes; then 81 cleanly.
    mode = 0;
    send(8'hF0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_load_ready", load_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_serial_out", serial_out, 1'b0);
    check("midrst_done", done, 1'b0);
    sbq.delete();
    wq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(8'h81);
    drain("81");

`ifdef LAB6_PAR2SER_BACK2BACK_EN
    // 12 then 34 with no idle gap and two done pulses 8 cycles apart.
    begin
      int base;
      mode = 0;
      done_cycles.delete();
      send(8'h12);
      base = ov_low;
      send(8'h34);
      check("b2b_no_gap", ov_low, base);
      drain("b2b");
      check("b2b_done_count", done_cycles.size(), 2);
      if (done_cycles.size() == 2) begin
        check("b2b_done_spacing", done_cycles[1] - done_cycles[0], 8);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
